// File: rtl/dmux_pkg.sv
// dmux_pkg: shared widths, types and helpers for the dmux_stream demultiplexer.
package dmux_pkg;

    localparam int ERR_CNT_W = 8;
    localparam int CNT_W     = 16;

    typedef logic [CNT_W-1:0] ch_cnt_t;

    // Holding-register occupancy: EMPTY (no word held) or FULL (one word held).
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } dmux_state_t;

    // Select width: enough bits to name every channel, never less than one.
    function automatic int sel_w(input int ch_n);
        return (ch_n > 1) ? $clog2(ch_n) : 1;
    endfunction

endpackage

// File: rtl/dmux_ch_cnt.sv
// dmux_ch_cnt: single-channel 16-bit transfer counter, wraps 0xFFFF -> 0.
module dmux_ch_cnt
    import dmux_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    en,
    output ch_cnt_t cnt
);

    ch_cnt_t cnt_r;

    // Count one per enabled cycle; natural overflow provides the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (en) begin
            cnt_r <= cnt_r + ch_cnt_t'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/dmux_stream.sv
// dmux_stream: registered 1-to-CH_N stream demultiplexer with valid/ready per
// channel and out-of-range select detection.
// Optional per-channel drain counters are built when DMUX_STREAM_CNT_EN is
// defined; otherwise cnt_flat is tied to zero (port list identical).
module dmux_stream
    import dmux_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CH_N   = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [sel_w(CH_N)-1:0]  sel,
    input  logic [DATA_W-1:0]       in,
    output logic [CH_N*DATA_W-1:0]  out,
    output logic [CH_N-1:0]         out_valid,
    input  logic [CH_N-1:0]         out_ready,
    output logic                    err,
    output logic [ERR_CNT_W-1:0]    err_cnt,
    output logic [CH_N*CNT_W-1:0]   cnt_flat
);

    localparam int SEL_W = sel_w(CH_N);
    // Channel count widened by one bit so CH_N itself is representable.
    localparam logic [SEL_W:0] CH_N_L = (SEL_W+1)'(CH_N);

    dmux_state_t            state_r, state_n_s;
    logic [SEL_W-1:0]       cur_ch_r;
    logic [DATA_W-1:0]      data_r;
    logic                   err_r;
    logic [ERR_CNT_W-1:0]   err_cnt_r;

    logic                   full_s;
    logic                   sel_ok_s;
    logic                   drain_s;
    logic                   ready_s;
    logic                   accept_s;
    logic                   load_s;
    logic                   bad_s;
    logic [CH_N-1:0]        valid_vec_s;
    logic [CH_N-1:0]        drain_vec_s;
    logic [CH_N*DATA_W-1:0] out_s;

    // Output decode from registers only, plus the per-channel drain vector.
    always_comb begin
        valid_vec_s = '0;
        drain_vec_s = '0;
        out_s       = '0;
        full_s      = (state_r == ST_FULL);
        for (int k = 0; k < CH_N; k++) begin
            valid_vec_s[k]              = full_s && (cur_ch_r == SEL_W'(k));
            drain_vec_s[k]              = valid_vec_s[k] && out_ready[k];
            out_s[k*DATA_W +: DATA_W]   = valid_vec_s[k] ? data_r : {DATA_W{1'b0}};
        end
        drain_s  = |drain_vec_s;
        ready_s  = !full_s || drain_s;
        accept_s = in_valid && ready_s;
        sel_ok_s = ({1'b0, sel} < CH_N_L);
        load_s   = accept_s && sel_ok_s;
        bad_s    = accept_s && !sel_ok_s;
    end

    // Next-state: load on valid accept, empty on drain without reload.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            ST_EMPTY: state_n_s = load_s ? ST_FULL : ST_EMPTY;
            ST_FULL:  state_n_s = (drain_s && !load_s) ? ST_EMPTY : ST_FULL;
            default:  state_n_s = ST_EMPTY;
        endcase
    end

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Held word and destination; dropped words leave both untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r   <= '0;
            cur_ch_r <= '0;
        end else if (load_s) begin
            data_r   <= in;
            cur_ch_r <= sel;
        end else begin
            data_r   <= data_r;
            cur_ch_r <= cur_ch_r;
        end
    end

    // Error pulse and saturating error count for out-of-range selects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r     <= 1'b0;
            err_cnt_r <= '0;
        end else begin
            err_r <= bad_s;
            if (bad_s && (err_cnt_r != {ERR_CNT_W{1'b1}})) begin
                err_cnt_r <= err_cnt_r + ERR_CNT_W'(1);
            end else begin
                err_cnt_r <= err_cnt_r;
            end
        end
    end

`ifdef DMUX_STREAM_CNT_EN
    for (genvar g = 0; g < CH_N; g++) begin : g_cnt
        dmux_ch_cnt u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (drain_vec_s[g]),
            .cnt   (cnt_flat[g*CNT_W +: CNT_W])
        );
    end
`else
    assign cnt_flat = '0;
`endif

    assign in_ready  = ready_s;
    assign out       = out_s;
    assign out_valid = valid_vec_s;
    assign err       = err_r;
    assign err_cnt   = err_cnt_r;

endmodule
